// File: rtl/muldiv_hl.sv
// ============================================================================
// Module   : muldiv_hl
// Brief    : HI/LO unit: multi-cycle multiplier, radix-2 restoring divider,
//            MTHI/MTLO writes, combinational MFHI/MFLO read select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_hl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hl_opt,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = $clog2(WIDTH + 2);
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_ma;
    logic [2*WIDTH-1:0]     r_mb;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_r;
    logic [WIDTH-1:0]       r_d;
    logic [WIDTH-1:0]       r_a;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_dz;

    logic                   w_signed;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH:0]         w_rs;
    logic [WIDTH:0]         w_diff;
    logic                   w_ge;

    // op[0] clear selects the signed variant for both MULT and DIV
    assign w_signed = ~op[0];
    assign w_neg_a  = w_signed & a[WIDTH-1];
    assign w_neg_b  = w_signed & b[WIDTH-1];
    assign w_abs_a  = w_neg_a ? (~a + 1'b1) : a;
    assign w_abs_b  = w_neg_b ? (~b + 1'b1) : b;

    assign w_prod   = r_ma * r_mb;

    // One restoring step: shift next dividend bit in, subtract if it fits
    assign w_rs     = {r_r, r_q[WIDTH-1]};
    assign w_diff   = w_rs - {1'b0, r_d};
    assign w_ge     = ~w_diff[WIDTH];

    assign dout = hl_opt ? r_hi : r_lo;
    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_a     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        case (op)
                            3'b000, 3'b001: begin
                                r_ma    <= {{WIDTH{w_signed & a[WIDTH-1]}}, a};
                                r_mb    <= {{WIDTH{w_signed & b[WIDTH-1]}}, b};
                                r_state <= S_MUL;
                                r_busy  <= 1'b1;
                            end
                            3'b010, 3'b011: begin
                                r_q     <= w_abs_a;
                                r_r     <= '0;
                                r_d     <= w_abs_b;
                                r_a     <= a;
                                r_neg_q <= w_neg_a ^ w_neg_b;
                                r_neg_r <= w_neg_a;
                                r_dz    <= (b == '0);
                                r_state <= S_DIV;
                                r_busy  <= 1'b1;
                            end
                            3'b100: begin
                                r_hi   <= a;
                                r_done <= 1'b1;
                            end
                            3'b101: begin
                                r_lo   <= a;
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_cnt == c_mul_last) begin
                        {r_hi, r_lo} <= w_prod;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    r_r <= w_ge ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
                    r_q <= {r_q[WIDTH-2:0], w_ge};
                    if (r_cnt == c_div_last) begin
                        r_state <= S_FIX;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    // Divide-by-zero overrides the magnitude result entirely
                    if (r_dz) begin
                        r_lo <= '1;
                        r_hi <= r_a;
                    end else begin
                        r_lo <= r_neg_q ? (~r_q + 1'b1) : r_q;
                        r_hi <= r_neg_r ? (~r_r + 1'b1) : r_r;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/muldiv_hl.md
Name: muldiv_hl

Overview:
Parametrised HI/LO unit for the MIPS datapath. It holds HI/LO and computes them itself: a multi-cycle multiplier (signed/unsigned) and a radix-2 iterative divider (signed/unsigned), plus direct MTHI/MTLO writes. It sits beside the ALU in EX. MFHI/MFLO read through a combinational select. The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO width (>= 4).
MUL_LAT, 2, multiply latency in clock edges from acceptance to HI/LO commit (>= 1).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted on a rising edge when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
b  input  WIDTH  multiplier / divisor
hl_opt  input  1  read select: 1 = HI, 0 = LO
dout  output  WIDTH  hl_opt ? hi : lo, combinational
busy  output  1  multiply/divide in progress
done  output  1  one-cycle pulse after HI/LO commit

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, done=0, FSM→IDLE, counter=0, operands/partials discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- Acceptance: start=1 and busy=0 at edge E0. a, b and op are latched at E0. start while busy=1 is ignored; there is no queueing.
- MTHI/MTLO: hi (or lo) ← a at E0. busy stays 0. done=1 for the cycle after E0. The other register is unchanged.
- No-op codes (11x): no state change and no done pulse.
- MULT/MULTU: IDLE→MUL at E0. busy=1 after E0. At edge E0+MUL_LAT, {hi,lo} ← full 2·WIDTH-bit product. MULT sign-extends both operands; MULTU zero-extends them. busy→0 and done=1 for one cycle after the commit edge.
- DIV/DIVU: IDLE→DIV at E0. Operands are converted to magnitudes (DIV only).
  - WIDTH restoring iterations, one per edge, then FIX for sign correction. Commit occurs at E0+WIDTH+1.
  - Quotient → lo, remainder → hi. The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero, both variants: lo = all ones, hi = a. Total latency is unchanged.
  - DIV of most-negative by −1: lo = most-negative, hi = 0. This is the natural result and is not trapped.
- busy rises only after the accepting edge, so acceptance is gated by the registered busy, not by start.
- dout reflects the old hi/lo while busy. It shows the new value in the cycle after the commit edge, i.e. the same cycle done is high.
- hi/lo are never partially written; both update on the same edge for MUL/DIV.
- Counter is sized ceil(log2(WIDTH+2)) bits and wraps only through reset or return to IDLE.

Test Plan:
- WIDTH=32, MUL_LAT=2. MULT a=0xFFFFFFFE, b=3 → busy high 2 cycles. After 2nd edge: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done single pulse.
- MULTU a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → after 33 edges: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- Boundary: DIVU 7/0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678, hl_opt=1 → dout=0x12345678 the next cycle, busy stays 0. MTLO a=0xCAFEF00D leaves hi intact.
- Start DIV, pulse start (MULT) at cycle 5 → ignored; DIV result unchanged. In a new DIV, assert rst at cycle 10 → busy=0, hi=lo=0 immediately, no done pulse.
